// File: rtl/fpadd_operand_feeder.sv
// Collects an A/B FP32 operand stream into pairs for an FP32 adder, conditioning
// NaN/Inf/subnormal/zero words on entry and counting handed-off pairs.
module fpadd_operand_feeder #(
  parameter int          FLUSH_SUB = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [1:0]       out_exc,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        load_a, load_b, handoff;
  logic [31:0] cond_word;
  logic [1:0]  cond_flag;

  // bit1: NaN/Inf replaced, bit0: subnormal flushed; signed zero collapses to +0
  always_comb begin
    cond_word = in_data;
    cond_flag = '0;
    if (in_data[30:23] == 8'hFF) begin
      cond_word = '0;
      cond_flag = 2'b10;
    end else if (in_data[30:23] == 8'h00) begin
      if (in_data[22:0] == 23'd0) begin
        cond_word = '0;
      end else if (FLUSH_SUB != 0) begin
        cond_word = '0;
        cond_flag = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    case (state)
      WAIT_A: begin
        if (in_valid) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        // flush drops the held A and swallows any word offered alongside it
        if (flush) begin
          state_next = WAIT_A;
        end else if (in_valid) begin
          load_b     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (out_ready) begin
          load_a     = in_valid;
          state_next = in_valid ? WAIT_B : WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  assign handoff = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      out_exc  <= '0;
      pair_cnt <= '0;
      exc_cnt  <= '0;
    end else begin
      if (load_a) begin
        op_a    <= cond_word;
        out_exc <= cond_flag;
      end
      if (load_b) begin
        op_b    <= cond_word;
        out_exc <= out_exc | cond_flag;
      end
      if (handoff) begin
        if (pair_cnt != '1) pair_cnt <= pair_cnt + CNT_W'(1);
        if ((out_exc != 2'b00) && (exc_cnt != '1)) exc_cnt <= exc_cnt + CNT_W'(1);
      end
    end
  end

endmodule
